ani_sequencer: RTL and testbench
================================

// Module: ani_sequencer
// PURPOSE
//  Frame/animation sequencer for the 7-segment display path. Steps a frame index 0..N-1 at a programmable rate.
//  N comes from the animation->frame-count lookup, driven combinationally from ani_out and returned on lim_in.
//  Selects the animation either from the switches (manual) or by auto-advancing after a fixed number of loops.
//  Feeds the segment pattern decoder.
// PARAMETERS
//  BASE_DIV      10_000_000  clocks per frame at div_sel=0 (10 MHz clk -> 1 frame/s)
//  DIV_W         24          prescaler counter width; BASE_DIV < 2**DIV_W
//  LOOPS_PER_ANI 4           full frame loops before auto-advance (1..15)
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  reset, synchronous, active-low
//  ena        in   1  design enable; low forces IDLE
//  auto_mode  in   1  1: auto-advance animations; 0: follow ani_sel
//  ani_sel    in   6  manual animation select
//  div_sel    in   3  rate select; frame period = BASE_DIV >> div_sel clocks
//  pause      in   1  level; hold current frame
//  step       in   1  single-cycle pulse; advance one frame while paused
//  lim_in     in   5  frame count for ani_out; 0 encodes 32
//  ani_out    out  6  current animation index
//  frame      out  5  current frame index
//  frame_stb  out  1  1-cycle pulse when frame or ani_out changes
//  wrap_stb   out  1  1-cycle pulse when frame wraps to 0 from the last frame
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): ani_out=0, frame=0, frame_stb=0, wrap_stb=0, loop_cnt=0, prescaler=0, state=IDLE.
//  States: IDLE, LOAD, RUN, PAUSE.
//   IDLE : outputs held. ena=1 -> LOAD.
//   LOAD : one cycle. ani_out<=ani_sel if auto_mode=0, else unchanged.
//          Sets frame=0, prescaler=0, loop_cnt=0 and frame_stb=1. -> RUN, or -> PAUSE if pause=1.
//   RUN  : prescaler counts 0..(BASE_DIV>>div_sel)-1. At terminal count -> tick.
//          tick: frame advances (see wrap rule) and frame_stb=1.
//          pause=1 -> PAUSE; the same-cycle tick is dropped.
//   PAUSE: prescaler held at 0. step=1 -> one frame advance and frame_stb=1. pause=0 -> RUN.
//   Any state: ena=0 -> IDLE next cycle, with outputs held.
//  Wrap rule: last = (lim_in==0) ? 31 : lim_in-1.
//   If frame >= last, frame<=0 and wrap_stb=1; otherwise frame<=frame+1.
//   lim_in=1: frame stays 0, and every advance is a wrap.
//  Auto-advance: on a wrap with auto_mode=1, loop_cnt++.
//   When loop_cnt reaches LOOPS_PER_ANI: ani_out<=next(ani_out), loop_cnt=0, frame=0.
//   next() = ani_out+1 with wrap 63->0.
//  Manual change: in RUN/PAUSE with auto_mode=0 and ani_sel!=ani_out -> LOAD.
//   This takes priority over tick/step in the same cycle (the tick is lost).
//  auto_mode toggling 1->0 is treated as a manual change if ani_sel differs.
//  Latency: ani_sel change -> ani_out update is 2 clocks (compare cycle + LOAD).
//  div_sel change mid-count: the new terminal count applies immediately.
//   If prescaler >= the new terminal, tick next cycle and reset.
//  Strobes are registered and never high in IDLE.
// CONFIGURATION
//  SEQ_SHUFFLE_EN defined: next() is a 6-bit maximal LFSR (x^6+x^5+1) seeded from ani_out.
//   Seed value 0 maps to 1, so animation 0 is only reachable via manual select or reset.
//  SEQ_SHUFFLE_EN undefined: sequential next() as above. Ports are identical in both builds.
// STRUCTURE
//  Shared package ani_pkg: ANI_W=6, FRM_W=5, state encoding (IDLE=0, LOAD=1, RUN=2, PAUSE=3),
//   and a function last_frame(lim) implementing the 0->31 rule.
//  Sub-module frame_prescaler (clk, rst_n, run, div_sel -> tick) holds the DIV_W counter.
//  FSM, frame counter, loop counter and next() logic stay in ani_sequencer.
//  lim_in comes from the lookup block, instantiated by the parent (not in this module).
// TESTING
//  Use BASE_DIV=8 for all scenarios.
//  1. Reset: rst_n=0 for 2 clocks mid-run -> ani_out=0, frame=0, strobes 0, IDLE; ena=1 -> frame_stb at LOAD.
//  2. Manual: auto_mode=0, ani_sel=1, lim_in=12, div_sel=0 -> frame 0..11 every 8 clocks.
//     Then frame 11->0 with wrap_stb=1.
//  3. Limit 32: lim_in=0 -> frame counts 0..31, and 31->0 wraps.
//     lim_in=1 -> frame stays 0, with wrap_stb on every tick.
//  4. Auto: auto_mode=1, LOOPS_PER_ANI=4, lim_in=2 -> ani_out increments after the 4th wrap.
//     Start ani_out=63 -> becomes 0; with SEQ_SHUFFLE_EN, follows the LFSR sequence from seed.
//  5. Pause/step: pause=1 at a tick cycle -> no advance. Three step pulses -> frame +3, each with frame_stb.
//     Release pause -> first tick BASE_DIV clocks later.
//  6. Priority: ani_sel change in the same cycle as a tick -> LOAD, frame=0, no intermediate frame value.

Source files
------------

// File: rtl/ani_pkg.sv
// Shared types and helpers for the animation sequencer: widths, FSM encoding
// and the frame-count to last-frame mapping.
package ani_pkg;
    localparam int ANI_W = 6;
    localparam int FRM_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_PAUSE = 2'd3
    } seq_state_t;

    // A frame count of 0 stands for 32 frames, so its last index is 31.
    function automatic logic [FRM_W-1:0] last_frame(input logic [FRM_W-1:0] lim);
        return (lim == '0) ? '1 : lim - FRM_W'(1);
    endfunction
endpackage

// File: rtl/ani_sequencer_if.sv
// Control/status bundle between the sequencer and its parent (switches,
// frame-count lookup and segment pattern decoder).
interface ani_sequencer_if;
    import ani_pkg::*;

    logic             ena;
    logic             auto_mode;
    logic [ANI_W-1:0] ani_sel;
    logic [2:0]       div_sel;
    logic             pause;
    logic             step;
    logic [FRM_W-1:0] lim_in;
    logic [ANI_W-1:0] ani_out;
    logic [FRM_W-1:0] frame;
    logic             frame_stb;
    logic             wrap_stb;

    modport master (
        output ena, auto_mode, ani_sel, div_sel, pause, step, lim_in,
        input  ani_out, frame, frame_stb, wrap_stb
    );

    modport slave (
        input  ena, auto_mode, ani_sel, div_sel, pause, step, lim_in,
        output ani_out, frame, frame_stb, wrap_stb
    );
endinterface

// File: rtl/frame_prescaler.sv
// Frame-rate prescaler: counts while run is high and pulses tick on the
// terminal count (BASE_DIV >> div_sel) - 1; the count clears whenever run drops.
module frame_prescaler #(
    parameter int BASE_DIV = 10_000_000,
    parameter int DIV_W    = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [2:0] div_sel,
    output logic       tick
);
    localparam logic [DIV_W-1:0] BASE = DIV_W'(BASE_DIV);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_period;
    logic [DIV_W-1:0] w_term;

    // The comparison is >= so a shorter period chosen mid-count fires at once.
    always_comb begin
        w_period = BASE >> div_sel;
        w_term   = (w_period <= DIV_W'(1)) ? '0 : w_period - DIV_W'(1);
    end

    assign tick = run && (r_cnt >= w_term);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!run || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end
endmodule

// File: rtl/ani_sequencer.sv
// Frame/animation sequencer for the 7-segment path. Define SEQ_SHUFFLE_EN to
// auto-advance animations in 6-bit LFSR order instead of sequentially.
module ani_sequencer
    import ani_pkg::*;
#(
    parameter int BASE_DIV      = 10_000_000,
    parameter int DIV_W         = 24,
    parameter int LOOPS_PER_ANI = 4
) (
    input logic            clk,
    input logic            rst_n,
    ani_sequencer_if.slave bus
);
    localparam logic [3:0] LOOP_LAST = 4'(LOOPS_PER_ANI - 1);

    seq_state_t       r_state;
    seq_state_t       w_next;
    logic [ANI_W-1:0] r_ani;
    logic [FRM_W-1:0] r_frame;
    logic             r_fstb;
    logic             r_wstb;
    logic [3:0]       r_loops;

    logic             w_manual;
    logic             w_run;
    logic             w_tick;
    logic             w_load;
    logic             w_adv;
    logic             w_wrap;

    function automatic logic [ANI_W-1:0] next_ani(input logic [ANI_W-1:0] cur);
`ifdef SEQ_SHUFFLE_EN
        logic [ANI_W-1:0] seed;
        seed = (cur == '0) ? ANI_W'(1) : cur;
        return {seed[ANI_W-2:0], seed[5] ^ seed[4]};
`else
        return cur + ANI_W'(1);
`endif
    endfunction

    // A differing manual select reloads and wins over any same-cycle tick/step.
    assign w_manual = !bus.auto_mode && (bus.ani_sel != r_ani);
    assign w_run    = bus.ena && (r_state == ST_RUN) && !w_manual && !bus.pause;
    assign w_wrap   = (r_frame >= last_frame(bus.lim_in));

    frame_prescaler #(
        .BASE_DIV (BASE_DIV),
        .DIV_W    (DIV_W)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (w_run),
        .div_sel (bus.div_sel),
        .tick    (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (!bus.ena) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_next = ST_LOAD;
                ST_LOAD:  w_next = bus.pause ? ST_PAUSE : ST_RUN;
                ST_RUN: begin
                    if (w_manual)       w_next = ST_LOAD;
                    else if (bus.pause) w_next = ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (w_manual)        w_next = ST_LOAD;
                    else if (!bus.pause) w_next = ST_RUN;
                end
                default:  w_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_load = bus.ena && (r_state == ST_LOAD);
        w_adv  = w_tick ||
                 (bus.ena && (r_state == ST_PAUSE) && !w_manual && bus.step);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ani   <= '0;
            r_frame <= '0;
            r_fstb  <= 1'b0;
            r_wstb  <= 1'b0;
            r_loops <= '0;
        end else begin
            r_fstb <= 1'b0;
            r_wstb <= 1'b0;
            if (w_load) begin
                r_ani   <= bus.auto_mode ? r_ani : bus.ani_sel;
                r_frame <= '0;
                r_loops <= '0;
                r_fstb  <= 1'b1;
            end else if (w_adv) begin
                r_fstb <= 1'b1;
                if (w_wrap) begin
                    r_frame <= '0;
                    r_wstb  <= 1'b1;
                    if (bus.auto_mode) begin
                        if (r_loops == LOOP_LAST) begin
                            r_ani   <= next_ani(r_ani);
                            r_loops <= '0;
                        end else begin
                            r_loops <= r_loops + 4'd1;
                        end
                    end
                end else begin
                    r_frame <= r_frame + FRM_W'(1);
                end
            end
        end
    end

    assign bus.ani_out   = r_ani;
    assign bus.frame     = r_frame;
    assign bus.frame_stb = r_fstb;
    assign bus.wrap_stb  = r_wstb;
endmodule

// File: tb/tb_ani_sequencer.sv
// Directed bench for ani_sequencer with a cycle-level behavioural model and
// hand-computed checkpoints (BASE_DIV=8, LOOPS_PER_ANI=4).
module tb_ani_sequencer;
    localparam int BASE  = 8;
    localparam int LOOPS = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    ani_sequencer_if bus();

    ani_sequencer #(
        .BASE_DIV      (BASE),
        .DIV_W         (24),
        .LOOPS_PER_ANI (LOOPS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: what the outputs must be after each edge, from the behaviour rules.
    int m_ani, m_frame, m_loops, m_elapsed;
    bit m_fstb, m_wstb, m_on, m_fresh, m_held, m_valid;

    function automatic int model_next(input int a);
`ifdef SEQ_SHUFFLE_EN
        int s;
        s = (a == 0) ? 1 : a;
        return ((s * 2) % 64) + (((s >> 5) ^ (s >> 4)) & 1);
`else
        return (a + 1) % 64;
`endif
    endfunction

    task automatic model_advance();
        int last;
        last   = (bus.lim_in == 0) ? 31 : int'(bus.lim_in) - 1;
        m_fstb = 1'b1;
        if (m_frame >= last) begin
            m_frame = 0;
            m_wstb  = 1'b1;
            if (bus.auto_mode) begin
                m_loops++;
                if (m_loops == LOOPS) begin
                    m_loops = 0;
                    m_ani   = model_next(m_ani);
                end
            end
        end else begin
            m_frame++;
        end
    endtask

    always @(posedge clk) begin
        int period;
        if (!rst_n) begin
            m_ani = 0; m_frame = 0; m_loops = 0; m_elapsed = 0;
            m_fstb = 0; m_wstb = 0; m_on = 0; m_fresh = 0; m_held = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_fstb = 0;
            m_wstb = 0;
            if (!bus.ena) begin
                m_on = 0; m_fresh = 0; m_held = 0; m_elapsed = 0;
            end else if (!m_on) begin
                m_on = 1; m_fresh = 1;
            end else if (m_fresh) begin
                if (!bus.auto_mode) m_ani = int'(bus.ani_sel);
                m_frame = 0; m_loops = 0; m_elapsed = 0;
                m_fstb = 1; m_fresh = 0; m_held = bus.pause;
            end else if (!bus.auto_mode && int'(bus.ani_sel) != m_ani) begin
                m_fresh = 1; m_elapsed = 0;
            end else if (m_held) begin
                if (bus.step) model_advance();
                if (!bus.pause) m_held = 0;
                m_elapsed = 0;
            end else if (bus.pause) begin
                m_held = 1; m_elapsed = 0;
            end else begin
                period = BASE >> bus.div_sel;
                if (period < 1) period = 1;
                if (m_elapsed >= period - 1) begin
                    model_advance();
                    m_elapsed = 0;
                end else begin
                    m_elapsed++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            n_vec++;
            if (bus.ani_out !== 6'(m_ani) || bus.frame !== 5'(m_frame) ||
                bus.frame_stb !== m_fstb || bus.wrap_stb !== m_wstb) begin
                n_err++;
                $display("FAIL model t=%0t: ani/frame/fstb/wstb got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                         $time, bus.ani_out, bus.frame, bus.frame_stb, bus.wrap_stb,
                         m_ani, m_frame, m_fstb, m_wstb);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_eq(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

`ifdef SEQ_SHUFFLE_EN
    localparam int AFTER_63 = 62;
`else
    localparam int AFTER_63 = 0;
`endif

    initial begin
        rst_n = 1'b0;
        bus.ena = 0; bus.auto_mode = 0; bus.ani_sel = 6'd1; bus.div_sel = 3'd0;
        bus.pause = 0; bus.step = 0; bus.lim_in = 5'd12;
        cyc(3);
        expect_eq("reset ani", int'(bus.ani_out), 0);
        expect_eq("reset frame", int'(bus.frame), 0);
        expect_eq("reset fstb", int'(bus.frame_stb), 0);

        // Manual, 12 frames, one frame per 8 clocks
        rst_n = 1'b1; bus.ena = 1;
        cyc(2);
        expect_eq("load ani", int'(bus.ani_out), 1);
        expect_eq("load fstb", int'(bus.frame_stb), 1);
        cyc(88);
        expect_eq("frame 11", int'(bus.frame), 11);
        cyc(8);
        expect_eq("wrap frame", int'(bus.frame), 0);
        expect_eq("wrap wstb", int'(bus.wrap_stb), 1);

        // Reset mid-run, then reload
        cyc(5);
        rst_n = 1'b0;
        cyc(2);
        expect_eq("midrst ani", int'(bus.ani_out), 0);
        expect_eq("midrst frame", int'(bus.frame), 0);
        expect_eq("midrst wstb", int'(bus.wrap_stb), 0);
        rst_n = 1'b1;
        cyc(2);
        expect_eq("reload fstb", int'(bus.frame_stb), 1);
        expect_eq("reload ani", int'(bus.ani_out), 1);

        // 32 frames via lim_in=0, then lim_in=1
        bus.lim_in = 5'd0; bus.ani_sel = 6'd2; bus.div_sel = 3'd2;
        cyc(2);
        expect_eq("lim0 ani", int'(bus.ani_out), 2);
        cyc(62);
        expect_eq("lim0 frame31", int'(bus.frame), 31);
        cyc(2);
        expect_eq("lim0 wrap", int'(bus.wrap_stb), 1);
        bus.lim_in = 5'd1;
        cyc(2);
        expect_eq("lim1 wstb a", int'(bus.wrap_stb), 1);
        cyc(2);
        expect_eq("lim1 wstb b", int'(bus.wrap_stb), 1);
        expect_eq("lim1 frame", int'(bus.frame), 0);

        // Auto advance from 63
        bus.ani_sel = 6'd63; bus.div_sel = 3'd3; bus.lim_in = 5'd2;
        cyc(2);
        expect_eq("auto start", int'(bus.ani_out), 63);
        bus.auto_mode = 1;
        cyc(7);
        expect_eq("auto before", int'(bus.ani_out), 63);
        cyc(1);
        expect_eq("auto after", int'(bus.ani_out), AFTER_63);
        expect_eq("auto wstb", int'(bus.wrap_stb), 1);
        cyc(20);
        bus.auto_mode = 0;
        cyc(2);
        expect_eq("auto off ani", int'(bus.ani_out), 63);

        // Pause at a tick, three steps, release
        bus.ani_sel = 6'd5; bus.lim_in = 5'd12; bus.div_sel = 3'd0;
        cyc(2);
        expect_eq("pause load", int'(bus.ani_out), 5);
        cyc(7);
        bus.pause = 1;
        cyc(1);
        expect_eq("pause drop", int'(bus.frame), 0);
        for (int k = 1; k <= 3; k++) begin
            bus.step = 1;
            cyc(1);
            expect_eq("step frame", int'(bus.frame), k);
            expect_eq("step fstb", int'(bus.frame_stb), 1);
            bus.step = 0;
            cyc(2);
        end
        bus.pause = 0;
        cyc(8);
        expect_eq("release hold", int'(bus.frame), 3);
        cyc(1);
        expect_eq("release tick", int'(bus.frame), 4);

        // Manual change on a tick cycle
        cyc(7);
        bus.ani_sel = 6'd7;
        cyc(1);
        expect_eq("prio frame", int'(bus.frame), 4);
        expect_eq("prio fstb", int'(bus.frame_stb), 0);
        cyc(1);
        expect_eq("prio ani", int'(bus.ani_out), 7);
        expect_eq("prio frame0", int'(bus.frame), 0);

        // Shorter period chosen mid-count ticks at once
        cyc(5);
        bus.div_sel = 3'd2;
        cyc(1);
        expect_eq("div change", int'(bus.frame), 1);
        cyc(10);

        // Disable holds outputs, re-enable reloads
        bus.ena = 0;
        cyc(1);
        expect_eq("idle fstb", int'(bus.frame_stb), 0);
        bus.step = 1;
        cyc(4);
        bus.step = 0;
        bus.ena = 1;
        cyc(2);
        expect_eq("reenable fstb", int'(bus.frame_stb), 1);
        cyc(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
